instr_fetch_unit: RTL and testbench

//  Program-counter and instruction-register block. It is the consumer of the controller's fetch/PC strobes (loadIR, loadPC, incPC, selA).

---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and imem (slave).
// Request/address are held by the master until the slave returns ack with data.
interface instr_fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC and instruction register with a req/ack imem fetch FSM (IDLE/FETCH/ERR).
// Define FETCH_TIMEOUT_EN to enable the FETCH watchdog that traps into ERR.
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                en,
  input  logic                loadIR,
  input  logic                loadPC,
  input  logic                incPC,
  input  logic                selA,
  instr_fetch_unit_if.master  imem,
  output logic [3:0]          opcode,
  output logic [INSTR_W-5:0]  operand,
  output logic [PC_W-1:0]     pc,
  output logic                ir_valid,
  output logic                stall,
  output logic                fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [PC_W-1:0]     r_addr;
  logic                r_irv;

  logic                w_fetch;
  logic                w_jump;
  logic                w_inc;
  logic                w_start;
  logic                w_done;
  logic                w_to_hit;
  logic [PC_W+INSTR_W-5:0] w_ext;
  logic [PC_W-1:0]     w_tgt;

  assign w_fetch = loadIR;
  assign w_jump  = loadPC & selA & ~loadIR;
  assign w_inc   = incPC & ~w_jump;
  assign w_start = (r_state == S_IDLE) & w_fetch;
  assign w_done  = (r_state == S_FETCH) & imem.imem_ack;

  assign w_ext   = {{PC_W{1'b0}}, r_ir[INSTR_W-5:0]};
  assign w_tgt   = w_ext[PC_W-1:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] r_cnt;

  assign w_to_hit = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!en) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state == S_FETCH && !imem.imem_ack && !w_to_hit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!en) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_fetch) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_ack) w_state_nxt = S_IDLE;
        else if (w_to_hit) w_state_nxt = S_ERR;
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = (r_state == S_FETCH);
    stall         = (r_state == S_FETCH) | (r_state == S_ERR);
`ifdef FETCH_TIMEOUT_EN
    fetch_err     = (r_state == S_ERR);
`else
    fetch_err     = 1'b0;
`endif
  end

  // The address latches the pre-update PC, so a same-cycle jump/inc is not fetched.
  always_ff @(posedge clk) begin
    if (!en) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_addr <= '0;
      r_irv  <= 1'b0;
    end else begin
      r_irv <= w_done;
      if (w_done)  r_ir   <= imem.imem_rdata;
      if (w_start) r_addr <= r_pc;
      if (r_state != S_ERR) begin
        if (w_jump)     r_pc <= w_tgt;
        else if (w_inc) r_pc <= r_pc + PC_W'(1);
      end
    end
  end

  assign imem.imem_addr = r_addr;
  assign opcode         = r_ir[INSTR_W-1 -: 4];
  assign operand        = r_ir[INSTR_W-5:0];
  assign pc             = r_pc;
  assign ir_valid       = r_irv;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, PC wrap, timeout cases
// and a randomized run against a transaction-level reference model.
module tb_instr_fetch_unit;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic en, loadIR, loadPC, incPC, selA;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [7:0] pc;
  logic ir_valid, stall, fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch_unit #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .en(en), .loadIR(loadIR), .loadPC(loadPC),
    .incPC(incPC), .selA(selA), .imem(bus),
    .opcode(opcode), .operand(operand), .pc(pc),
    .ir_valid(ir_valid), .stall(stall), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Reference model: program counter, instruction, outstanding read
  int m_pc, m_ir, m_addr, m_wait;
  bit m_busy, m_irv, m_err;

  typedef struct {
    logic en, lir, lpc, inc, sa, ack;
    logic [7:0] rd;
    logic [7:0] pc, ir;
    logic req;
    logic [7:0] addr;
    logic irv, stall, err;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, lir, lpc, inc, sa, ak,
                       input logic [7:0] rd);
    en = e; loadIR = lir; loadPC = lpc; incPC = inc; selA = sa;
    bus.imem_ack = ak; bus.imem_rdata = rd;
  endtask

  task automatic model_step();
    bit jmp;
    int old;
    if (!en) begin
      m_pc = 0; m_ir = 0; m_addr = 0; m_wait = 0;
      m_busy = 0; m_irv = 0; m_err = 0;
    end else if (m_err) begin
      m_irv = 0;
    end else begin
      jmp = loadPC && selA && !loadIR;
      old = m_pc;
      m_irv = 0;
      if (jmp) m_pc = m_ir % 16;
      else if (incPC) m_pc = (m_pc + 1) % 256;
      if (m_busy) begin
        if (bus.imem_ack) begin
          m_ir = int'(bus.imem_rdata); m_busy = 0; m_irv = 1;
        end else begin
          m_wait++;
`ifdef FETCH_TIMEOUT_EN
          if (m_wait == TIMEOUT) begin m_err = 1; m_busy = 0; end
`endif
        end
      end else if (loadIR) begin
        m_busy = 1; m_addr = old; m_wait = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
    chk({tag, "_op"}, 32'(opcode), 32'(m_ir / 16));
    chk({tag, "_opd"}, 32'(operand), 32'(m_ir % 16));
    chk({tag, "_req"}, 32'(bus.imem_req), 32'(m_busy));
    chk({tag, "_addr"}, 32'(bus.imem_addr), 32'(m_addr));
    chk({tag, "_irv"}, 32'(ir_valid), 32'(m_irv));
    chk({tag, "_stall"}, 32'(stall), 32'(m_busy | m_err));
    chk({tag, "_err"}, 32'(fetch_err), 32'(m_err));
  endtask

  initial begin
    int irv_cnt;
    drive(0, 1, 0, 0, 0, 1, 8'hFF);

    //        en lir lpc inc sa ack rd      pc     ir     req addr  irv st er
    tbl[0]  = '{0, 1, 0, 0, 0, 1, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 1, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, 0, 0, 8'h00, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 1, 0, 0, 8'h00, 8'h02, 8'h00, 0, 8'h00, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 8'h00, 8'h02, 8'h00, 1, 8'h02, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 1, 0, 1, 8'h35, 8'h03, 8'h35, 0, 8'h02, 1, 0, 0};
    tbl[6]  = '{1, 0, 1, 1, 1, 0, 8'h00, 8'h05, 8'h35, 0, 8'h02, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 8'h00, 8'h05, 8'h35, 1, 8'h05, 0, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h05, 8'h35, 1, 8'h05, 0, 1, 0};
    tbl[9]  = '{1, 0, 0, 1, 0, 0, 8'h00, 8'h06, 8'h35, 1, 8'h05, 0, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 0, 1, 8'h4A, 8'h06, 8'h4A, 0, 8'h05, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h06, 8'h4A, 0, 8'h05, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 8'h11, 8'h06, 8'h4A, 0, 8'h05, 0, 0, 0};
    tbl[13] = '{1, 1, 1, 0, 1, 0, 8'h00, 8'h06, 8'h4A, 1, 8'h06, 0, 1, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 1, 8'h73, 8'h06, 8'h73, 0, 8'h06, 1, 0, 0};
    tbl[15] = '{1, 0, 1, 1, 1, 0, 8'h00, 8'h03, 8'h73, 0, 8'h06, 0, 0, 0};
    tbl[16] = '{1, 0, 1, 0, 0, 0, 8'h00, 8'h03, 8'h73, 0, 8'h06, 0, 0, 0};
    tbl[17] = '{1, 1, 0, 0, 0, 0, 8'h00, 8'h03, 8'h73, 1, 8'h03, 0, 1, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].en, tbl[i].lir, tbl[i].lpc, tbl[i].inc, tbl[i].sa,
            tbl[i].ack, tbl[i].rd);
      tick();
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      chk($sformatf("vec%0d_op", i), 32'(opcode), 32'(tbl[i].ir[7:4]));
      chk($sformatf("vec%0d_opd", i), 32'(operand), 32'(tbl[i].ir[3:0]));
      chk($sformatf("vec%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_irv", i), 32'(ir_valid), 32'(tbl[i].irv));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
      chk($sformatf("vec%0d_err", i), 32'(fetch_err), 32'(tbl[i].err));
    end

    // PC wrap from 0xFF to 0x00
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    tick();
    drive(1, 0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 255; i++) tick();
    chk("wrap_pc_ff", 32'(pc), 32'h0000_00FF);
    tick();
    chk("wrap_pc_00", 32'(pc), 32'h0000_0000);

    // Fetch with 3-cycle ack latency; exactly one ir_valid pulse
    drive(1, 1, 0, 0, 0, 0, 8'h00);
    tick();
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    irv_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lat_hold_addr", 32'(bus.imem_addr), 32'h0);
      chk("lat_no_irv", 32'(ir_valid), 32'h0);
    end
    drive(1, 0, 0, 0, 0, 1, 8'h9C);
    tick();
    irv_cnt += int'(ir_valid);
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      irv_cnt += int'(ir_valid);
    end
    chk("lat_irv_pulses", 32'(irv_cnt), 32'h1);
    chk("lat_opcode", 32'(opcode), 32'h9);
    chk("lat_operand", 32'(operand), 32'hC);

`ifdef FETCH_TIMEOUT_EN
    // No ack: ERR after 16 FETCH cycles, sticky until en=0
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    tick();
    drive(1, 1, 0, 0, 0, 0, 8'h00);
    tick();
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_err", 32'(fetch_err), 32'h0);
      chk("to_wait_stall", 32'(stall), 32'h1);
    end
    tick();
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_err_stall", 32'(stall), 32'h1);
    chk("to_err_req", 32'(bus.imem_req), 32'h0);
    drive(1, 1, 1, 1, 1, 1, 8'h55);
    tick();
    check_model("to_err_hold");
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    tick();
    chk("to_clr_err", 32'(fetch_err), 32'h0);
    chk("to_clr_stall", 32'(stall), 32'h0);

    // Ack on the 16th FETCH cycle wins over the timeout
    drive(1, 1, 0, 0, 0, 0, 8'h00);
    tick();
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 15; i++) tick();
    drive(1, 0, 0, 0, 0, 1, 8'hE7);
    tick();
    chk("to_edge_err", 32'(fetch_err), 32'h0);
    chk("to_edge_irv", 32'(ir_valid), 32'h1);
    chk("to_edge_op", 32'(opcode), 32'hE);
    chk("to_edge_opd", 32'(operand), 32'h7);
`endif

    // Randomized run against the reference model
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    tick();
    for (int i = 0; i < 2000; i++) begin
      drive(logic'($urandom_range(0, 49) != 0),
            logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 4) < 2),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 19) < 7),
            8'($urandom));
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
